// File: rtl/cache_assoc_pkg.sv
// Shared defines and package for the set-associative lookup cache.
// Holds the reset level, the idle/miss data word, the address slicing
// widths and the sweep FSM state type used by cache_assoc and its bench.

`ifndef CACHE_ASSOC_DEFINES
`define CACHE_ASSOC_DEFINES
`define RstEnable     1'b1
`define RstDisable    1'b0
`define NopInst       32'h00000000
`define CacheAddrW    32
`define CacheOffW     2
`define CacheTagW(idx_w) (`CacheAddrW - (idx_w) - `CacheOffW)
`endif

package cache_assoc_pkg;

  // Invalidation sweep runs from reset and on flush; IDLE serves traffic.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_e;

  localparam int ADDR_W = `CacheAddrW;
  localparam int OFF_W  = `CacheOffW;

  // Tag width left over once the word offset and set index are removed.
  function automatic int tag_width(input int idx_w);
    return `CacheTagW(idx_w);
  endfunction

endpackage

// File: rtl/cache_plru.sv
// Tree pseudo-LRU helper for one cache set.
// Each node bit names the half that holds the next victim (0 = lower ways).
// o_victim depends only on i_bits; o_bits is i_bits with i_way made MRU.

module cache_plru
  #(
    parameter  int WAYS   = 2,
    localparam int WAY_W  = $clog2(WAYS),
    localparam int PLRU_W = WAYS - 1
  ) (
    input  logic [PLRU_W-1:0] i_bits,
    input  logic [WAY_W-1:0]  i_way,
    output logic [WAY_W-1:0]  o_victim,
    output logic [PLRU_W-1:0] o_bits
  );

  generate
    if (WAYS == 4) begin : g_four
      // bit 0 = root, bit 1 = ways 0/1, bit 2 = ways 2/3
      assign o_victim = i_bits[0] ? {1'b1, i_bits[2]} : {1'b0, i_bits[1]};
      assign o_bits   = {(i_way[1] ? ~i_way[0] : i_bits[2]),
                         (i_way[1] ? i_bits[1] : ~i_way[0]),
                         ~i_way[1]};
    end else begin : g_two
      assign o_victim = i_bits[0];
      assign o_bits   = ~i_way[0];
    end
  endgenerate

endmodule

// File: rtl/cache_assoc.sv
// Set-associative lookup cache with one-cycle registered hit/data output,
// word fills, tree-PLRU replacement and a one-set-per-cycle invalidation
// sweep after reset or flush.
// Optional build macro CACHE_STATS_EN adds hit_cnt_o / miss_cnt_o counters.

module cache_assoc
  import cache_assoc_pkg::*;
  #(
    parameter int WAYS   = 2,
    parameter int IDX_W  = 9,
    parameter int DATA_W = 32
  ) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en_i,
    input  logic [31:0]       rd_addr_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              fill_en_i,
    input  logic [31:0]       fill_addr_i,
    input  logic [DATA_W-1:0] fill_data_i,
    input  logic              flush_i,
    output logic              busy_o
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
  );

  localparam int SETS   = 2 ** IDX_W;
  localparam int TAG_W  = tag_width(IDX_W);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int PLRU_W = WAYS - 1;
  localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(`NopInst);

  // Sweep FSM
  sweep_state_e      r_state, w_state_next;
  logic [IDX_W-1:0]  r_cnt, w_cnt_next;

  // Storage
  logic [TAG_W-1:0]  r_tag  [WAYS][SETS];
  logic [DATA_W-1:0] r_word [WAYS][SETS];
  logic [WAYS-1:0]   r_valid [SETS];
  logic [PLRU_W-1:0] r_plru  [SETS];

  // Registered outputs
  logic              r_hit;
  logic [DATA_W-1:0] r_data;

  // Request decode
  logic              w_busy, w_rd_acc, w_fill_acc;
  logic [IDX_W-1:0]  w_rd_idx, w_fill_idx;
  logic [TAG_W-1:0]  w_rd_tag, w_fill_tag;
  logic              w_rd_hit;
  logic [WAY_W-1:0]  w_rd_way;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_fill_tag_hit, w_fill_has_inv;
  logic [WAY_W-1:0]  w_fill_tag_way, w_fill_inv_way, w_fill_way, w_plru_victim;
  logic [PLRU_W-1:0] w_rd_plru_next, w_fill_plru_next;
  logic [WAY_W-1:0]  w_rd_victim_unused;
  logic              w_addr_unused;

  assign w_addr_unused = &{1'b0, rd_addr_i[OFF_W-1:0], fill_addr_i[OFF_W-1:0]};

  assign w_busy     = (r_state == ST_SWEEP);
  // A flush in IDLE pre-empts any lookup or fill presented with it.
  assign w_rd_acc   = rd_en_i   & ~w_busy & ~flush_i;
  assign w_fill_acc = fill_en_i & ~w_busy & ~flush_i;

  assign w_rd_idx   = rd_addr_i[OFF_W +: IDX_W];
  assign w_rd_tag   = rd_addr_i[ADDR_W-1 -: TAG_W];
  assign w_fill_idx = fill_addr_i[OFF_W +: IDX_W];
  assign w_fill_tag = fill_addr_i[ADDR_W-1 -: TAG_W];

  // Sweep state register; reset restarts the sweep from set 0.
  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst == `RstEnable) begin
      r_state <= ST_SWEEP;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state: flush in IDLE starts a sweep; the sweep ends after the last set.
  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned
    // (which would infer a latch).
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (flush_i) begin
          w_state_next = ST_SWEEP;
          w_cnt_next   = '0;
        end
      end
      ST_SWEEP: begin
        if (r_cnt == IDX_W'(SETS - 1)) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_SWEEP;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Lookup compare against pre-edge contents; at most one way matches.
  always_comb begin
    w_rd_hit  = 1'b0;
    w_rd_way  = '0;
    w_rd_word = NOP_WORD;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_rd_idx][w] && (r_tag[w][w_rd_idx] == w_rd_tag)) begin
        w_rd_hit  = 1'b1;
        w_rd_way  = WAY_W'(w);
        w_rd_word = r_word[w][w_rd_idx];
      end
    end
  end

  // Fill candidates: way already holding the tag, and lowest invalid way.
  always_comb begin
    w_fill_tag_hit = 1'b0;
    w_fill_tag_way = '0;
    w_fill_has_inv = 1'b0;
    w_fill_inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_fill_idx][w] && (r_tag[w][w_fill_idx] == w_fill_tag)) begin
        w_fill_tag_hit = 1'b1;
        w_fill_tag_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_fill_idx][w]) begin
        w_fill_has_inv = 1'b1;
        w_fill_inv_way = WAY_W'(w);
      end
    end
  end

  assign w_fill_way = w_fill_tag_hit ? w_fill_tag_way :
                      w_fill_has_inv ? w_fill_inv_way : w_plru_victim;

  cache_plru #(.WAYS(WAYS)) u_plru_rd (
    .i_bits   (r_plru[w_rd_idx]),
    .i_way    (w_rd_way),
    .o_victim (w_rd_victim_unused),
    .o_bits   (w_rd_plru_next)
  );

  cache_plru #(.WAYS(WAYS)) u_plru_fill (
    .i_bits   (r_plru[w_fill_idx]),
    .i_way    (w_fill_way),
    .o_victim (w_plru_victim),
    .o_bits   (w_fill_plru_next)
  );

  // Valid/PLRU bits: cleared set-by-set in SWEEP, else updated by hit then fill.
  always_ff @(posedge clk) begin
    // NOTE: these arrays take no reset; the sweep clears them one set per
    // cycle, which keeps them mappable to RAM-style storage.
    if (r_state == ST_SWEEP) begin
      r_valid[r_cnt] <= '0;
      r_plru[r_cnt]  <= '0;
    end else begin
      if (w_rd_acc && w_rd_hit) begin
        r_plru[w_rd_idx] <= w_rd_plru_next;
      end
      // Written after the hit update so a fill to the same set wins.
      if (w_fill_acc) begin
        r_valid[w_fill_idx][w_fill_way] <= 1'b1;
        r_plru[w_fill_idx]              <= w_fill_plru_next;
      end
    end
  end

  // Tag and data arrays: written only by accepted fills.
  always_ff @(posedge clk) begin
    if (w_fill_acc) begin
      r_tag[w_fill_way][w_fill_idx]  <= w_fill_tag;
      r_word[w_fill_way][w_fill_idx] <= fill_data_i;
    end
  end

  // Registered lookup result; NOP word whenever no hit was accepted.
  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      r_hit  <= 1'b0;
      r_data <= NOP_WORD;
    end else begin
      r_hit  <= w_rd_acc & w_rd_hit;
      r_data <= (w_rd_acc & w_rd_hit) ? w_rd_word : NOP_WORD;
    end
  end

  assign hit_o  = r_hit;
  assign data_o = r_data;
  assign busy_o = w_busy;

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  // Outcome counters for accepted lookups; wrap at 2**32, cleared by reset only.
  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_rd_acc) begin
      if (w_rd_hit) r_hit_cnt  <= r_hit_cnt + 1'b1;
      else          r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_cache_assoc.sv
// Scoreboard bench for cache_assoc (WAYS=2, IDX_W=9, DATA_W=32).
// The driver pushes the hand-computed response of every lookup it issues;
// a negedge monitor pops and compares it one cycle later and otherwise
// checks the idle response. Stats checks are built with CACHE_STATS_EN.

module tb_cache_assoc;

  localparam logic [31:0] NOP = `NopInst;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic        hit_o;
  logic [31:0] data_o;
  logic        fill_en;
  logic [31:0] fill_addr;
  logic [31:0] fill_data;
  logic        flush;
  logic        busy_o;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  cache_assoc #(.WAYS(2), .IDX_W(9), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en_i     (rd_en),
    .rd_addr_i   (rd_addr),
    .hit_o       (hit_o),
    .data_o      (data_o),
    .fill_en_i   (fill_en),
    .fill_addr_i (fill_addr),
    .fill_data_i (fill_data),
    .flush_i     (flush),
    .busy_o      (busy_o)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt),
    .miss_cnt_o  (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;
  logic lk_q;
  int   busy_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
  endtask

  // Remember whether a lookup was presented at the last rising edge.
  always @(posedge clk) lk_q <= rd_en;

  // Free-running count of busy cycles, sampled mid-cycle.
  always @(negedge clk) if (busy_o === 1'b1) busy_cnt <= busy_cnt + 1;

  // Monitor: pop the expected response of a lookup, or check the idle response.
  always @(negedge clk) begin
    if (mon_en) begin
      if (lk_q === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_underflow: lookup response with empty scoreboard");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check({e.name, "_hit"}, hit_o, e.hit);
          check({e.name, "_data"}, data_o, e.data);
        end
      end else begin
        check("idle_hit", hit_o, 1'b0);
        check("idle_data", data_o, NOP);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rst     = 1'b0;
    rd_en   = 1'b0;
    fill_en = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic set_lookup(input logic [31:0] a, input logic h,
                            input logic [31:0] d, input string nm);
    exp_t e;
    e.hit  = h;
    e.data = d;
    e.name = nm;
    sb_q.push_back(e);
    rd_en   = 1'b1;
    rd_addr = a;
  endtask

  task automatic set_fill(input logic [31:0] a, input logic [31:0] d);
    fill_en   = 1'b1;
    fill_addr = a;
    fill_data = d;
  endtask

  // Wait (bounded) for the sweep to finish.
  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      if (busy_o !== 1'b1) break;
      n++;
    end
    #1;
    check({nm, "_ends"}, busy_o, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; rd_en = 1'b0; rd_addr = '0; fill_en = 1'b0;
    fill_addr = '0; fill_data = '0; flush = 1'b0;

    // Reset and the start-up sweep
    tick();
    base   = busy_cnt;
    mon_en = 1'b1;
    check("rst_busy", busy_o, 1'b1);
    tick(); tick();
    set_lookup(32'h0000_0000, 1'b0, NOP, "busy_lookup"); tick();
    set_fill(32'h0000_2000, 32'h1111_1111); tick();
    wait_idle("rst_sweep");
    check("rst_sweep_len", busy_cnt - base, 512);
    set_lookup(32'h0000_2000, 1'b0, NOP, "dropped_fill"); tick();

    // Two-way replacement in set 0
    set_fill(32'h0000_0000, 32'hA0A0_A0A0); tick();
    set_fill(32'h0000_0800, 32'hA8A8_A8A8); tick();
    set_lookup(32'h0000_0000, 1'b1, 32'hA0A0_A0A0, "w2_lk0"); tick();
    set_fill(32'h0000_1000, 32'hB000_B000); tick();
    set_lookup(32'h0000_0800, 1'b0, NOP, "w2_evicted"); tick();
    set_lookup(32'h0000_0000, 1'b1, 32'hA0A0_A0A0, "w2_kept"); tick();
    set_lookup(32'h0000_1000, 1'b1, 32'hB000_B000, "w2_new"); tick();

    // Refill of a resident tag reuses its way; next-cycle lookup hits
    set_fill(32'h0000_1000, 32'hDEAD_BEEF); tick();
    set_lookup(32'h0000_1000, 1'b1, 32'hDEAD_BEEF, "fill_then_hit"); tick();
    set_lookup(32'h0000_0000, 1'b1, 32'hA0A0_A0A0, "refill_same_way"); tick();

    // Same-cycle lookup and fill on an empty set
    set_lookup(32'h0000_0040, 1'b0, NOP, "same_cycle_pre");
    set_fill(32'h0000_0040, 32'h4040_4040); tick();
    set_lookup(32'h0000_0040, 1'b1, 32'h4040_4040, "same_cycle_post"); tick();

    // Flush with simultaneous lookup and fill, plus a flush mid-sweep
    set_lookup(32'h0000_0000, 1'b0, NOP, "flush_prio");
    set_fill(32'h0000_0080, 32'h8080_8080);
    flush = 1'b1;
    tick();
    base = busy_cnt;
    check("flush_busy", busy_o, 1'b1);
    repeat (50) tick();
    set_lookup(32'h0000_1000, 1'b0, NOP, "sweep_lookup"); tick();
    repeat (50) tick();
    flush = 1'b1; tick();
    wait_idle("flush_sweep");
    check("flush_sweep_len", busy_cnt - base, 512);
    set_lookup(32'h0000_0000, 1'b0, NOP, "post_flush_0"); tick();
    set_lookup(32'h0000_0800, 1'b0, NOP, "post_flush_800"); tick();
    set_lookup(32'h0000_1000, 1'b0, NOP, "post_flush_1000"); tick();
    set_lookup(32'h0000_0040, 1'b0, NOP, "post_flush_40"); tick();
    set_lookup(32'h0000_0080, 1'b0, NOP, "post_flush_80"); tick();

    // Reset part-way through a sweep restarts it from set 0
    set_fill(32'h0000_0000, 32'h1234_5678); tick();
    set_lookup(32'h0000_0000, 1'b1, 32'h1234_5678, "pre_rst_hit"); tick();
    flush = 1'b1; tick();
    repeat (200) tick();
    rst = 1'b1; tick();
    base = busy_cnt;
    check("rst_mid_busy", busy_o, 1'b1);
    wait_idle("rst_restart");
    check("rst_restart_len", busy_cnt - base, 512);
    set_lookup(32'h0000_0000, 1'b0, NOP, "post_rst_0"); tick();

`ifdef CACHE_STATS_EN
    // Counters clear on reset, then count 3 hits and 2 misses
    rst = 1'b1; tick();
    check("stats_rst_hits", hit_cnt, 32'd0);
    check("stats_rst_misses", miss_cnt, 32'd0);
    wait_idle("stats_sweep");
    set_fill(32'h0000_0004, 32'h00C0_FFEE); tick();
    repeat (3) begin
      set_lookup(32'h0000_0004, 1'b1, 32'h00C0_FFEE, "stats_hit"); tick();
    end
    repeat (2) begin
      set_lookup(32'h0000_0008, 1'b0, NOP, "stats_miss"); tick();
    end
    tick();
    check("stats_hits", hit_cnt, 32'd3);
    check("stats_misses", miss_cnt, 32'd2);
`endif

    tick(); tick(); tick();
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_assoc.md
CACHE_ASSOC -- requirements
Module: cache_assoc

Interface
REQ-001 Parameter WAYS, default 2, associativity; legal values 2 or 4.
REQ-002 Parameter IDX_W, default 9, set-index width; sets = 2**IDX_W.
REQ-003 Parameter DATA_W, default 32, word width; address fixed at 32 bits, word-aligned, tag = addr[31:IDX_W+2].
REQ-004 clk  in  1  clock; one clock domain, all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 rd_en_i  in  1  lookup request.
REQ-007 rd_addr_i  in  32  lookup address.
REQ-008 hit_o  out  1  registered lookup hit.
REQ-009 data_o  out  DATA_W  registered hit word; `NopInst on miss or idle.
REQ-010 fill_en_i  in  1  install-word request.
REQ-011 fill_addr_i  in  32  install address.
REQ-012 fill_data_i  in  DATA_W  install word.
REQ-013 flush_i  in  1  invalidate-all request, single-cycle pulse.
REQ-014 busy_o  out  1  high while invalidation sweep runs.

Function
REQ-015 Lookup latency exactly 1 cycle: rd_en_i at edge N yields hit_o/data_o valid after edge N+1; hit_o=0, data_o=`NopInst in any cycle without an accepted lookup.
REQ-016 Hit = any way with valid set and stored tag equal to the lookup tag; at most one way can match.
REQ-017 FSM states SWEEP and IDLE; rst forces SWEEP with set counter 0; flush_i in IDLE enters SWEEP with counter 0.
REQ-018 SWEEP clears valid bits and PLRU bits of one set per cycle, counter ascending; leaves to IDLE after set 2**IDX_W-1; busy_o=1 throughout SWEEP, so 2**IDX_W busy cycles.
REQ-019 In SWEEP, lookups return miss, fills are dropped, and flush_i has no effect (sweep is not restarted).
REQ-020 In IDLE, flush_i asserted together with rd_en_i/fill_en_i takes priority: the lookup returns miss, the fill is dropped.
REQ-021 Fill victim selection, in order: the way already holding the tag; else the lowest-numbered invalid way; else the tree-PLRU victim.
REQ-022 Tree-PLRU uses WAYS-1 bits per set; every hit or fill moves the accessed way to most-recently-used.
REQ-023 When a lookup and a fill occur in the same cycle, the lookup sees pre-fill contents; if both target one set, the fill's PLRU update wins.
REQ-024 A fill followed by a lookup of the same address on the next cycle hits.

Reset
REQ-025 rst sets hit_o=0, data_o=`NopInst, busy_o=1, FSM=SWEEP, counter=0; tag and data arrays need no reset.
REQ-026 rst asserted mid-sweep restarts the sweep from set 0.

Configuration
REQ-027 With CACHE_STATS_EN defined, ports hit_cnt_o and miss_cnt_o (out, 32) are present; each counts accepted lookups by outcome, wraps at 2**32, and is cleared only by rst.
REQ-028 Without CACHE_STATS_EN, the stats ports and counters do not exist; all other behaviour is identical.

Structure
REQ-029 `NopInst, `RstEnable and the tag/index slice widths come from the shared defines file; no local redefinition.
REQ-030 The tree-PLRU victim/update logic is one sub-module, cache_plru, parametrised by WAYS.

Verification
REQ-031 rst for 1 cycle -> busy_o=1 for 512 cycles (IDX_W=9), then 0; lookup during busy -> hit_o=0, data_o=`NopInst.
REQ-032 Fill 0x00001000/0xDEADBEEF, then lookup 0x00001000 -> hit_o=1, data_o=0xDEADBEEF after 1 cycle.
REQ-033 WAYS=2: fill 0x0 and 0x800, lookup 0x0, fill 0x1000 -> lookups of 0x800 miss; 0x0 and 0x1000 hit.
REQ-034 Same-cycle lookup and fill of 0x40 on an empty set -> lookup misses; lookup of 0x40 on the next cycle hits.
REQ-035 Flush pulse after valid fills -> busy_o high for 512 cycles; all earlier addresses then miss; a flush pulse mid-sweep does not extend it.
REQ-036 With CACHE_STATS_EN: 3 hits and 2 misses -> hit_cnt_o=3, miss_cnt_o=2; rst clears both to 0.
